// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
// MemMode encodings are shared with the multicycle controller. The package also
// holds the access FSM state codes and the decode that rejects an access before
// any external cycle is started.
package mem_access_unit_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int WORD_W    = NUM_LANES * LANE_W;

  typedef enum logic [1:0] {
    MEM_MODE_WORD  = 2'b00,
    MEM_MODE_SBYTE = 2'b01,
    MEM_MODE_UBYTE = 2'b10,
    MEM_MODE_RSVD  = 2'b11
  } mem_mode_e;

  typedef enum logic [1:0] {
    MAU_IDLE   = 2'b00,
    MAU_ACCESS = 2'b01,
    MAU_RESP   = 2'b10,
    MAU_ERR    = 2'b11
  } mau_state_e;

  // Request fields captured in IDLE. The address is kept outside the struct
  // because its width is a parameter of the unit.
  typedef struct packed {
    logic              we;
    mem_mode_e         mode;
    logic [WORD_W-1:0] wdata;
  } mau_req_t;

  // An access is refused outright for the reserved mode and for an unaligned word.
  function automatic logic bad_access(input mem_mode_e mode, input logic [1:0] lo);
    return (mode == MEM_MODE_RSVD) || ((mode == MEM_MODE_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_unit.sv
// byte_lane_unit: combinational byte-lane steering for the memory access unit.
//   mode      in  access mode (word / signed byte / unsigned byte)
//   lane      in  addr[1:0], little-endian lane select
//   word      in  raw word returned by memory
//   wdata     in  store data (byte stores use wdata[7:0])
//   be        out byte enables, bit k covers bits [8k+7:8k]
//   wdata_rep out store data, low byte replicated on every lane for byte stores
//   ld_data   out load result, sign- or zero-extended for byte loads
module byte_lane_unit
  import mem_access_unit_pkg::*;
(
  input  mem_mode_e         mode,
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] wdata,
  output logic [NUM_LANES-1:0] be,
  output logic [WORD_W-1:0] wdata_rep,
  output logic [WORD_W-1:0] ld_data
);

  logic [NUM_LANES-1:0][LANE_W-1:0] word_lanes;
  logic [LANE_W-1:0]                sel;

  assign word_lanes = word;
  assign sel        = word_lanes[lane];

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign be[k] = (mode == MEM_MODE_WORD) || (lane == 2'(k));
    assign wdata_rep[LANE_W*k +: LANE_W] =
      (mode == MEM_MODE_WORD) ? wdata[LANE_W*k +: LANE_W] : wdata[LANE_W-1:0];
  end

  always_comb begin
    ld_data = word;
    case (mode)
      MEM_MODE_SBYTE: ld_data = {{(WORD_W-LANE_W){sel[LANE_W-1]}}, sel};
      MEM_MODE_UBYTE: ld_data = {{(WORD_W-LANE_W){1'b0}}, sel};
      default:        ld_data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: runs one load/store from the multicycle controller on a
// word-wide external memory port with a req/ack handshake.
//   clk, reset        clock; asynchronous active-low reset
//   req/addr/wdata/mem_write/mem_mode  access request, sampled only when idle
//   busy              access accepted and still waiting on memory
//   done / err        one-cycle completion / failure pulses
//   rdata             extended load result, held until the next successful load
//   ext_req/we/be/addr/wdata  external request, held until ext_ack
//   ext_ack/ext_rdata external completion and read word
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              mem_write,
  input  logic [1:0]        mem_mode,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] rdata,
  output logic              ext_req,
  output logic              ext_we,
  output logic [NUM_LANES-1:0] ext_be,
  output logic [ADDR_W-3:0] ext_addr,
  output logic [WORD_W-1:0] ext_wdata,
  input  logic              ext_ack,
  input  logic [WORD_W-1:0] ext_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mau_state_e        state, state_nxt;
  mau_req_t          rq_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] word_q, rdata_q, ld_data;
  logic [NUM_LANES-1:0] be;
  logic [CNT_W-1:0]  cnt;
  logic              tmo;
  logic              ld_resp;

  byte_lane_unit u_lanes (
    .mode      (rq_q.mode),
    .lane      (addr_q[1:0]),
    .word      (word_q),
    .wdata     (rq_q.wdata),
    .be        (be),
    .wdata_rep (ext_wdata),
    .ld_data   (ld_data)
  );

  // TIMEOUT == 0 disables the watchdog entirely.
  assign tmo = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= MAU_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MAU_IDLE:
        if (req) state_nxt = bad_access(mem_mode_e'(mem_mode), addr[1:0]) ? MAU_ERR : MAU_ACCESS;
      // ack takes priority over an expiring timeout in the same cycle
      MAU_ACCESS:
        if (ext_ack)  state_nxt = MAU_RESP;
        else if (tmo) state_nxt = MAU_ERR;
      default: state_nxt = MAU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rq_q    <= '{we: 1'b0, mode: MEM_MODE_WORD, wdata: '0};
      addr_q  <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      if (state == MAU_IDLE && req) begin
        rq_q   <= '{we: mem_write, mode: mem_mode_e'(mem_mode), wdata: wdata};
        addr_q <= addr;
      end
      // Counter idles at zero, so it is already clear on entry to ACCESS.
      if (state == MAU_ACCESS) begin
        cnt <= cnt + 1'b1;
        if (ext_ack && !rq_q.we) word_q <= ext_rdata;
      end else begin
        cnt <= '0;
      end
      if (ld_resp) rdata_q <= ld_data;
    end
  end

  // The new load result is visible during the RESP cycle itself, then held.
  assign ld_resp = (state == MAU_RESP) && !rq_q.we;
  assign rdata   = ld_resp ? ld_data : rdata_q;

  assign busy     = (state == MAU_ACCESS);
  assign done     = (state == MAU_RESP);
  assign err      = (state == MAU_ERR);
  assign ext_req  = (state == MAU_ACCESS);
  assign ext_we   = ext_req && rq_q.we;
  assign ext_be   = ext_req ? be : '0;
  assign ext_addr = addr_q[ADDR_W-1:2];

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [1:0]  mem_mode;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        ext_req, ext_we;
  logic [3:0]  ext_be;
  logic [29:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_ack;
  logic [31:0] ext_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] ref_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .wdata(wdata),
    .mem_write(mem_write), .mem_mode(mem_mode), .busy(busy), .done(done),
    .err(err), .rdata(rdata), .ext_req(ext_req), .ext_we(ext_we),
    .ext_be(ext_be), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access, called at a negedge. dly = ACCESS cycle index on which ack is
  // given; anything >= TIMEOUT means memory never answers. hold keeps req high
  // while busy to show it is not queued.
  task automatic do_access(input logic we, input logic [1:0] mode, input logic [31:0] a,
                           input logic [31:0] wd, input int dly, input bit hold);
    bit          bad, acked;
    int          n;
    logic [31:0] w, b, exp_wd, exp_rd;
    logic [3:0]  exp_be;
    bad    = (mode == 2'd3) || (mode == 2'd0 && a[1:0] != 2'd0);
    exp_be = (mode == 2'd0) ? 4'hF : 4'(1 << a[1:0]);
    exp_wd = (mode == 2'd0) ? wd : (wd & 32'hFF) * 32'h01010101;
    req = 1'b1; mem_write = we; mem_mode = mode; addr = a; wdata = wd;
    @(negedge clk);
    if (!hold) req = 1'b0;
    addr = $urandom; wdata = $urandom; mem_write = $urandom_range(0, 1);
    if (bad) begin
      req = 1'b0;
      chk("err_pulse", 32'(err), 1);
      chk("err_no_ext_req", 32'(ext_req), 0);
      chk("err_busy", 32'(busy), 0);
      chk("err_rdata_held", rdata, ref_rdata);
      @(negedge clk);
      chk("err_one_cycle", 32'(err), 0);
      chk("err_idle_ext_req", 32'(ext_req), 0);
      return;
    end
    acked = 0;
    n = 0;
    while (!acked) begin
      chk("ext_req", 32'(ext_req), 1);
      chk("busy", 32'(busy), 1);
      chk("ext_we", 32'(ext_we), 32'(we));
      chk("ext_be", 32'(ext_be), 32'(exp_be));
      chk("ext_addr", 32'(ext_addr), a >> 2);
      if (we) chk("ext_wdata", ext_wdata, exp_wd);
      if (n == dly) begin
        ext_ack = 1'b1;
        ext_rdata = mem[a[11:2]];
      end else begin
        ext_rdata = $urandom;
      end
      if (n == dly || n == TIMEOUT - 1) req = 1'b0;
      @(negedge clk);
      ext_ack = 1'b0;
      ext_rdata = $urandom;
      if (n == dly) acked = 1;
      else if (n == TIMEOUT - 1) break;
      n++;
    end
    if (acked) begin
      if (we) begin
        if (mode == 2'd0) mem[a[11:2]] = wd;
        else begin
          w = mem[a[11:2]];
          w[8*a[1:0] +: 8] = wd[7:0];
          mem[a[11:2]] = w;
        end
      end else begin
        w = mem[a[11:2]];
        b = (w >> (8 * a[1:0])) & 32'hFF;
        if (mode == 2'd0)      exp_rd = w;
        else if (mode == 2'd1) exp_rd = (b >= 128) ? b + 32'hFFFFFF00 : b;
        else                   exp_rd = b;
        ref_rdata = exp_rd;
      end
      chk("done_pulse", 32'(done), 1);
      chk("resp_err", 32'(err), 0);
      chk("resp_busy", 32'(busy), 0);
      chk("resp_ext_req", 32'(ext_req), 0);
      chk("resp_rdata", rdata, ref_rdata);
    end else begin
      chk("tmo_err", 32'(err), 1);
      chk("tmo_ext_req", 32'(ext_req), 0);
      chk("tmo_busy", 32'(busy), 0);
      chk("tmo_req_cycles", 32'(n + 1), 32'(TIMEOUT));
      chk("tmo_rdata", rdata, ref_rdata);
    end
    @(negedge clk);
    chk("post_done", 32'(done), 0);
    chk("post_err", 32'(err), 0);
    chk("post_ext_req", 32'(ext_req), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_rdata", rdata, ref_rdata);
  endtask

  initial begin
    int r, dly;
    reset = 1'b0; req = 1'b0; addr = '0; wdata = '0; mem_write = 1'b0;
    mem_mode = 2'd0; ext_ack = 1'b0; ext_rdata = '0; ref_rdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ext_req", 32'(ext_req), 0);
    chk("rst_ext_we", 32'(ext_we), 0);
    chk("rst_ext_be", 32'(ext_be), 0);
    chk("rst_ext_addr", 32'(ext_addr), 0);
    chk("rst_ext_wdata", ext_wdata, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b1;
    @(negedge clk);

    // LW, ack on the third ACCESS cycle
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    do_access(1'b0, 2'd0, 32'h100, 32'h0, 2, 0);
    chk("lw_value", rdata, 32'hDEADBEEF);
    // LB / LBU of top byte
    mem[32'h103 >> 2] = 32'h80112233;
    do_access(1'b0, 2'd1, 32'h103, 32'h0, 1, 0);
    chk("lb_value", rdata, 32'hFFFFFF80);
    do_access(1'b0, 2'd2, 32'h103, 32'h0, 0, 0);
    chk("lbu_value", rdata, 32'h00000080);
    // SB: byte replicated, rdata untouched
    do_access(1'b1, 2'd0 + 2'd1, 32'h202, 32'h000000A5, 1, 0);
    chk("sb_rdata_kept", rdata, 32'h00000080);
    // misaligned word and reserved mode
    do_access(1'b0, 2'd0, 32'h101, 32'h0, 0, 0);
    do_access(1'b0, 2'd3, 32'h104, 32'h0, 0, 0);
    do_access(1'b1, 2'd3, 32'h108, 32'h0, 0, 0);
    // timeout, and ack on the last allowed cycle
    do_access(1'b0, 2'd0, 32'h300, 32'h0, 1000, 0);
    do_access(1'b0, 2'd0, 32'h304, 32'h0, TIMEOUT - 1, 0);
    // req held high while busy is not queued
    do_access(1'b0, 2'd2, 32'h205, 32'h0, 3, 1);

    // reset in the middle of an access
    req = 1'b1; mem_write = 1'b1; mem_mode = 2'd1; addr = 32'h3F1; wdata = 32'h5A;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("mid_ext_req", 32'(ext_req), 1);
    #2 reset = 1'b0;
    #1;
    ref_rdata = '0;
    chk("abort_ext_req", 32'(ext_req), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ext_we", 32'(ext_we), 0);
    chk("abort_ext_be", 32'(ext_be), 0);
    chk("abort_ext_addr", 32'(ext_addr), 0);
    chk("abort_ext_wdata", ext_wdata, 0);
    chk("abort_rdata", rdata, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      dly = (r == 0) ? 1000 : $urandom_range(0, 4);
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                32'($urandom_range(0, 4095)), $urandom, dly, bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
